// File: rtl/cgc_pkg.sv
// Shared types and helpers for the clock-gate controller (clk_gate_ctrl).
package cgc_pkg;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAKE = 3'd2,
    ST_ON   = 3'd3,
    ST_IDLE = 3'd4
  } cgc_state_e;

  // Counter must hold the larger of the wake and idle reload values.
  function automatic int cgc_cnt_w(input int wake_cyc, input int idle_cyc);
    int m;
    m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cgc_client_fsm.sv
// Per-branch wake/idle sequencer: owns state, down-counter and the
// registered gate_en/ack pair for one gated clock branch.
module cgc_client_fsm
  import cgc_pkg::*;
#(
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic       out_clk,
  input  logic       out_rst_n,
  input  logic       req_s,
  input  logic       grant,
  output cgc_state_e state,
  output logic       gate_en,
  output logic       ack
);

  localparam int CW = cgc_cnt_w(WAKE_CYC, IDLE_CYC);

  logic [CW-1:0] cnt;

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      state   <= ST_OFF;
      cnt     <= '0;
      gate_en <= 1'b0;
      ack     <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (req_s) state <= ST_REQ;
        end
        ST_REQ: begin
          if (!req_s) begin
            state <= ST_OFF;
          end else if (grant) begin
            state   <= ST_WAKE;
            cnt     <= CW'(WAKE_CYC - 1);
            gate_en <= 1'b1;
          end
        end
        ST_WAKE: begin
          if (cnt == '0) begin
            state <= ST_ON;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ON: begin
          if (!req_s) begin
            ack <= 1'b0;
            if (IDLE_CYC == 0) begin
              state   <= ST_OFF;
              gate_en <= 1'b0;
            end else begin
              state <= ST_IDLE;
              cnt   <= CW'(IDLE_CYC - 1);
            end
          end
        end
        ST_IDLE: begin
          // A returning request beats expiry, even on the last count.
          if (req_s) begin
            state <= ST_ON;
            ack   <= 1'b1;
          end else if (cnt == '0) begin
            state   <= ST_OFF;
            gate_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_OFF;
          gate_en <= 1'b0;
          ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: request sync, round-robin wake arbiter, busy flag.
// Optional build macro CGC_FORCE_ON_EN adds cfg_force_on to hold gates open.
module clk_gate_ctrl
  import cgc_pkg::*;
#(
  parameter int NC       = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic          out_clk,
  input  logic          out_rst_n,
  input  logic [NC-1:0] req_async,
`ifdef CGC_FORCE_ON_EN
  input  logic [NC-1:0] cfg_force_on,
`endif
  output logic [NC-1:0] gate_en,
  output logic [NC-1:0] ack,
  output logic          busy
);

  localparam int RRW = (NC > 1) ? $clog2(NC) : 1;

  logic [NC-1:0]  req_p0, req_p1, req_p2;
  logic [NC-1:0]  grant;
  logic [NC-1:0]  fsm_gate;
  logic [NC-1:0]  not_off;
  cgc_state_e     st [NC];
  logic [RRW-1:0] rr_q, rr_d;
  logic           wake_busy;
  logic           found;
  int             cand;

  // Stage boundary: asynchronous requests into out_clk.
  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      req_p0 <= '0;
      req_p1 <= '0;
      req_p2 <= '0;
    end else begin
      req_p0 <= req_async;
      req_p1 <= req_p0;
      req_p2 <= req_p1;
    end
  end

  // Only one branch may be waking at a time; a dropped request is never granted.
  always_comb begin
    grant     = '0;
    rr_d      = rr_q;
    wake_busy = 1'b0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NC; i++) begin
      if (st[i] == ST_WAKE) wake_busy = 1'b1;
    end
    if (!wake_busy) begin
      for (int o = 0; o < NC; o++) begin
        cand = (int'(rr_q) + o) % NC;
        if (!found && st[cand] == ST_REQ && req_p2[cand]) begin
          grant[cand] = 1'b1;
          rr_d        = RRW'((cand + 1) % NC);
          found       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    not_off = '0;
    for (int i = 0; i < NC; i++) not_off[i] = (st[i] != ST_OFF);
  end

  // Stage boundary: arbiter pointer and busy flag.
  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      rr_q <= '0;
      busy <= 1'b0;
    end else begin
      rr_q <= rr_d;
      busy <= |not_off;
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_client
    cgc_client_fsm #(
      .WAKE_CYC (WAKE_CYC),
      .IDLE_CYC (IDLE_CYC)
    ) u_fsm (
      .out_clk   (out_clk),
      .out_rst_n (out_rst_n),
      .req_s     (req_p2[i]),
      .grant     (grant[i]),
      .state     (st[i]),
      .gate_en   (fsm_gate[i]),
      .ack       (ack[i])
    );
  end

`ifdef CGC_FORCE_ON_EN
  logic [NC-1:0] force_q;

  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) force_q <= '0;
    else            force_q <= cfg_force_on;
  end

  assign gate_en = fsm_gate | force_q;
`else
  assign gate_en = fsm_gate;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with NC=4, WAKE_CYC=4, IDLE_CYC=8.
module tb_clk_gate_ctrl;

  localparam int NC = 4;

  logic          out_clk = 1'b0;
  logic          out_rst_n;
  logic [NC-1:0] req_async;
  logic [NC-1:0] gate_en;
  logic [NC-1:0] ack;
  logic          busy;
`ifdef CGC_FORCE_ON_EN
  logic [NC-1:0] cfg_force_on;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NC-1:0] req;
    logic [NC-1:0] g;
    logic [NC-1:0] a;
    logic          b;
  } vec_t;

  vec_t tbl[$];

  always #5 out_clk = ~out_clk;

  clk_gate_ctrl #(.NC(NC), .WAKE_CYC(4), .IDLE_CYC(8)) dut (
    .out_clk      (out_clk),
    .out_rst_n    (out_rst_n),
    .req_async    (req_async),
`ifdef CGC_FORCE_ON_EN
    .cfg_force_on (cfg_force_on),
`endif
    .gate_en      (gate_en),
    .ack          (ack),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge out_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [NC-1:0] r, input logic [NC-1:0] g,
                              input logic [NC-1:0] a, input logic b, input int n);
    vec_t v;
    v.req = r; v.g = g; v.a = a; v.b = b;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic do_reset();
    out_rst_n = 1'b0;
    tick();
    out_rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || gate_en !== '0) && n < 40) begin
      tick();
      n++;
    end
    chk(name, {27'd0, busy, gate_en}, 32'd0);
  endtask

  initial begin
    int g_rise[NC];
    int a_rise;
    int bad;

    out_rst_n = 1'b0;
    req_async = '0;
`ifdef CGC_FORCE_ON_EN
    cfg_force_on = '0;
`endif
    tick();
    tick();
    chk("reset_gate", 32'(gate_en), 32'd0);
    chk("reset_ack",  32'(ack),     32'd0);
    chk("reset_busy", 32'(busy),    32'd0);
    out_rst_n = 1'b1;

    // Single wake then release on client 0, one record per clock edge.
    add(4'h1, 4'h0, 4'h0, 1'b0, 4);
    add(4'h1, 4'h1, 4'h0, 1'b1, 4);
    add(4'h1, 4'h1, 4'h1, 1'b1, 2);
    add(4'h0, 4'h1, 4'h1, 1'b1, 3);
    add(4'h0, 4'h1, 4'h0, 1'b1, 8);
    add(4'h0, 4'h0, 4'h0, 1'b1, 1);
    add(4'h0, 4'h0, 4'h0, 1'b0, 2);
    for (int i = 0; i < tbl.size(); i++) begin
      req_async = tbl[i].req;
      tick();
      chk($sformatf("single_step%0d_gate", i + 1), 32'(gate_en), 32'(tbl[i].g));
      chk($sformatf("single_step%0d_ack",  i + 1), 32'(ack),     32'(tbl[i].a));
      chk($sformatf("single_step%0d_busy", i + 1), 32'(busy),    32'(tbl[i].b));
    end

    // Contention from rr=0: wakes serialised 5 cycles apart.
    do_reset();
    for (int i = 0; i < NC; i++) g_rise[i] = -1;
    a_rise = -1;
    req_async = 4'hF;
    for (int n = 1; n <= 30; n++) begin
      tick();
      for (int i = 0; i < NC; i++) if (gate_en[i] && g_rise[i] < 0) g_rise[i] = n;
      if (ack[3] && a_rise < 0) a_rise = n;
    end
    for (int i = 0; i < NC; i++)
      chk($sformatf("contend_gate%0d_rise", i), 32'(g_rise[i]), 32'(5 + 5 * i));
    chk("contend_ack3_rise", 32'(a_rise), 32'd24);
    chk("contend_all_ack", 32'(ack), 32'hF);

    // Re-request during IDLE: ack returns without the gate ever dropping.
    bad = 0;
    req_async = 4'b1101;
    for (int n = 1; n <= 12; n++) begin
      if (n == 7) req_async = 4'hF;
      tick();
      if (gate_en[1] !== 1'b1) bad++;
      if (n == 3)  chk("idle_ack1_before_drop", 32'(ack[1]), 32'd1);
      if (n == 4)  chk("idle_ack1_dropped",     32'(ack[1]), 32'd0);
      if (n == 9)  chk("idle_ack1_still_low",   32'(ack[1]), 32'd0);
      if (n == 10) chk("idle_ack1_returned",    32'(ack[1]), 32'd1);
    end
    chk("idle_gate1_held", 32'(bad), 32'd0);

    req_async = '0;
    wait_idle("idle_after_rereq");

    // Short request pulse on client 2 while client 0 is waking.
    bad = 0;
    a_rise = -1;
    for (int n = 1; n <= 20; n++) begin
      req_async = (n == 4 || n == 5) ? 4'b0101 : 4'b0001;
      tick();
      if (gate_en[2] !== 1'b0) bad++;
      if (ack[0] && a_rise < 0) a_rise = n;
    end
    chk("pulse_gate2_never", 32'(bad), 32'd0);
    chk("pulse_ack0_rise", 32'(a_rise), 32'd9);
    chk("pulse_final_gate", 32'(gate_en), 32'h1);

    req_async = '0;
    wait_idle("idle_after_pulse");

    // Reset while client 0 is in WAKE, then a full wake afterwards.
    req_async = 4'h1;
    for (int n = 1; n <= 6; n++) tick();
    chk("midwake_gate_before", 32'(gate_en), 32'h1);
    out_rst_n = 1'b0;
    #1;
    chk("midwake_rst_gate", 32'(gate_en), 32'd0);
    chk("midwake_rst_ack",  32'(ack),     32'd0);
    chk("midwake_rst_busy", 32'(busy),    32'd0);
    tick();
    tick();
    out_rst_n = 1'b1;
    g_rise[0] = -1;
    a_rise = -1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (gate_en[0] && g_rise[0] < 0) g_rise[0] = n;
      if (ack[0] && a_rise < 0) a_rise = n;
    end
    chk("rewake_gate_rise", 32'(g_rise[0]), 32'd5);
    chk("rewake_ack_rise",  32'(a_rise),    32'd9);

    req_async = '0;
    wait_idle("idle_after_rewake");

`ifdef CGC_FORCE_ON_EN
    cfg_force_on = 4'b0001;
    tick();
    tick();
    chk("force_gate", 32'(gate_en), 32'h1);
    chk("force_ack",  32'(ack),     32'd0);
    chk("force_busy", 32'(busy),    32'd0);
    cfg_force_on = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
